redirection_ctrl_unit: RTL and testbench

- Hazard and forwarding control for the 5-stage MIPS pipeline; sits in ID, directly upstream of the EX-stage operand redirection muxes.
- Tracks destination-register info of the two instructions ahead of ID.
- Produces the registered 4-bit redirection_ctrl consumed in EX, and a load-use stall.
- Drives bubble insertion into ID/EX.

---
 rtl/redirection_ctrl_unit_if.sv | 45 ++++
 rtl/redirection_ctrl_unit.sv | 115 +++++++++++
 tb/tb_redirection_ctrl_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/redirection_ctrl_unit_if.sv
// Handshake bundle between the ID stage and the redirection control unit.
// The slave modport is the unit itself; the master modport is the ID-stage side.
// Optional macro: REDIRECTION_STALL_COUNT_EN adds the stall_count signal.
interface redirection_ctrl_unit_if #(
    parameter int REG_BITS = 5,
    parameter int CNT_W    = 32
);
    logic                id_valid;
    logic [REG_BITS-1:0] id_rs;
    logic [REG_BITS-1:0] id_rt;
    logic                id_rs_used;
    logic                id_rt_used;
    logic                id_wr_en;
    logic [REG_BITS-1:0] id_wr_reg;
    logic                id_is_load;
    logic                flush;
    logic [3:0]          redirection_ctrl;
    logic                stall;
    logic                ex_bubble;
`ifdef REDIRECTION_STALL_COUNT_EN
    logic [CNT_W-1:0]    stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_wr_en, id_wr_reg, id_is_load, flush,
        input  redirection_ctrl, stall, ex_bubble, stall_count
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_wr_en, id_wr_reg, id_is_load, flush,
        output redirection_ctrl, stall, ex_bubble, stall_count
    );
`else
    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_wr_en, id_wr_reg, id_is_load, flush,
        input  redirection_ctrl, stall, ex_bubble
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_wr_en, id_wr_reg, id_is_load, flush,
        output redirection_ctrl, stall, ex_bubble
    );
`endif
endinterface

// File: rtl/redirection_ctrl_unit.sv
// Hazard / forwarding control for a 5-stage MIPS pipeline, located in ID.
// Tracks the destination info of the instructions in EX and MEM, raises a
// one-cycle load-use stall, and registers the 4-bit operand redirection
// selection that the EX muxes use while the instruction sits in EX.
// Optional macro: REDIRECTION_STALL_COUNT_EN adds a wrapping stall counter.
module redirection_ctrl_unit #(
    parameter int REG_BITS = 5,
    parameter int CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    redirection_ctrl_unit_if.slave bus
);
    typedef struct packed {
        logic                valid;
        logic                wr_en;
        logic [REG_BITS-1:0] wr_reg;
        logic                is_load;
    } rec_t;

    // Reject nonsensical widths at elaboration time.
    generate
        if (REG_BITS < 1 || CNT_W < 1) begin : g_bad_cfg
            $error("redirection_ctrl_unit: REG_BITS and CNT_W must be >= 1");
        end
    endgenerate

    rec_t       e_reg;     // instruction currently in EX
    rec_t       m_reg;     // instruction currently in MEM
    rec_t       e_next;
    rec_t       id_rec;
    logic [3:0] ctrl_reg;
    logic [3:0] ctrl_next;
    logic       ex_bubble_reg;
    logic       stall_c;
    logic       advance;

    logic [REG_BITS-1:0] src  [2];
    logic                used [2];

    assign src[0]  = bus.id_rs;
    assign src[1]  = bus.id_rt;
    assign used[0] = bus.id_rs_used;
    assign used[1] = bus.id_rt_used;

    // A producer matches when it is live, writes, targets r, and r is not $0.
    function automatic logic hit(input rec_t x, input logic [REG_BITS-1:0] r);
        return x.valid && x.wr_en && (x.wr_reg == r) && (r != '0);
    endfunction

    // Load-use detection and the decision whether ID advances into EX.
    always_comb begin
        stall_c = 1'b0;
        advance = 1'b0;
        id_rec  = '0;
        e_next  = '0;
        stall_c = bus.id_valid && !bus.flush && e_reg.is_load &&
                  ((used[0] && hit(e_reg, src[0])) ||
                   (used[1] && hit(e_reg, src[1])));
        // Flush has priority: the killed instruction never stalls nor forwards.
        advance = bus.id_valid && !stall_c && !bus.flush;
        id_rec.valid   = bus.id_valid;
        id_rec.wr_en   = bus.id_wr_en;
        id_rec.wr_reg  = bus.id_wr_reg;
        id_rec.is_load = bus.id_is_load;
        if (advance) begin
            e_next = id_rec;
        end
    end

    // Per-operand selection: bit 2*gi from EX (alu_out), bit 2*gi+1 from MEM.
    // The younger producer in EX takes priority over MEM.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign ctrl_next[2*gi]   = advance && used[gi] &&
                                       hit(e_reg, src[gi]) && !e_reg.is_load;
            assign ctrl_next[2*gi+1] = advance && used[gi] &&
                                       hit(m_reg, src[gi]) && !ctrl_next[2*gi];
        end
    endgenerate

    // Pipeline tracking records and the registered EX-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_reg         <= '0;
            m_reg         <= '0;
            ctrl_reg      <= 4'b0000;
            ex_bubble_reg <= 1'b1;
        end else begin
            m_reg         <= e_reg;
            e_reg         <= e_next;
            ctrl_reg      <= ctrl_next;
            ex_bubble_reg <= !advance;
        end
    end

    assign bus.redirection_ctrl = ctrl_reg;
    assign bus.ex_bubble        = ex_bubble_reg;
    assign bus.stall            = stall_c;

`ifdef REDIRECTION_STALL_COUNT_EN
    logic [CNT_W-1:0] stall_count_reg;

    // Counts stall cycles; wraps naturally from all-ones to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_reg <= '0;
        end else if (stall_c) begin
            stall_count_reg <= stall_count_reg + CNT_W'(1);
        end
    end

    assign bus.stall_count = stall_count_reg;
`endif
endmodule

// File: tb/tb_redirection_ctrl_unit.sv
// Self-checking bench for redirection_ctrl_unit: directed scenarios with
// hand-computed expectations, then randomized traffic checked every cycle
// against a history-based reference model.
module tb_redirection_ctrl_unit;
    localparam int REG_BITS = 5;
    localparam int CNT_W    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    redirection_ctrl_unit_if #(.REG_BITS(REG_BITS), .CNT_W(CNT_W)) bus ();

    redirection_ctrl_unit #(.REG_BITS(REG_BITS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit started = 0;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // History of whatever entered EX each cycle (bubbles included); the last
    // entry is EX, the one before it is MEM.
    typedef struct {
        bit valid;
        bit wr_en;
        int wr_reg;
        bit is_load;
    } minst_t;

    minst_t     hist[$];
    logic [3:0] exp_ctrl;
    bit         exp_bubble;
    int unsigned exp_cnt;

    // Distance (1 = EX, 2 = MEM) to the youngest older writer of r, or 0.
    function automatic int writer_dist(input int r);
        if (r == 0) return 0;
        for (int d = 1; d <= 2; d++) begin
            minst_t x;
            x = hist[hist.size() - d];
            if (x.valid && x.wr_en && x.wr_reg == r) return d;
        end
        return 0;
    endfunction

    function automatic bit model_stall();
        bit s;
        s = 0;
        if (bus.id_valid && !bus.flush) begin
            if (bus.id_rs_used && writer_dist(int'(bus.id_rs)) == 1 && hist[hist.size()-1].is_load) s = 1;
            if (bus.id_rt_used && writer_dist(int'(bus.id_rt)) == 1 && hist[hist.size()-1].is_load) s = 1;
        end
        return s;
    endfunction

    function automatic logic [1:0] operand_sel(input bit u, input int r);
        int d;
        if (!u) return 2'b00;
        d = writer_dist(r);
        if (d == 1) return 2'b01;
        if (d == 2) return 2'b10;
        return 2'b00;
    endfunction

    // Advance the model at every rising edge using the inputs then applied.
    always @(posedge clk) begin
        minst_t b, n;
        bit st, adv;
        b = '{0, 0, 0, 0};
        if (rst) begin
            hist.delete();
            hist.push_back(b);
            hist.push_back(b);
            exp_ctrl   = 4'b0000;
            exp_bubble = 1;
            exp_cnt    = 0;
        end else if (hist.size() >= 2) begin
            st  = model_stall();
            adv = bus.id_valid && !st && !bus.flush;
            if (st) exp_cnt++;
            exp_ctrl   = adv ? {operand_sel(bus.id_rt_used, int'(bus.id_rt)),
                                operand_sel(bus.id_rs_used, int'(bus.id_rs))} : 4'b0000;
            exp_bubble = !adv;
            n = adv ? '{1, bus.id_wr_en, int'(bus.id_wr_reg), bus.id_is_load} : b;
            hist.push_back(n);
            while (hist.size() > 2) void'(hist.pop_front());
        end
    end

    // Compare process: every falling edge once the model is initialised.
    always @(negedge clk) begin
        if (started) begin
            chk("model_stall", {31'b0, bus.stall}, {31'b0, model_stall()});
            chk("model_ctrl", {28'b0, bus.redirection_ctrl}, {28'b0, exp_ctrl});
            chk("model_ex_bubble", {31'b0, bus.ex_bubble}, {31'b0, exp_bubble});
`ifdef REDIRECTION_STALL_COUNT_EN
            chk("model_stall_count", bus.stall_count, exp_cnt);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                         input bit we, input int wr, input bit ld, input bit fl);
        bus.id_valid   = v;
        bus.id_rs      = REG_BITS'(rs);
        bus.id_rt      = REG_BITS'(rt);
        bus.id_rs_used = rsu;
        bus.id_rt_used = rtu;
        bus.id_wr_en   = we;
        bus.id_wr_reg  = REG_BITS'(wr);
        bus.id_is_load = ld;
        bus.flush      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one ID instruction, check the combinational stall, then clock it.
    task automatic step(input string nm, input bit v, input int rs, input int rt, input bit rsu,
                        input bit rtu, input bit we, input int wr, input bit ld, input bit fl,
                        input bit exp_stall);
        drive(v, rs, rt, rsu, rtu, we, wr, ld, fl);
        #1;
        chk({nm, "_stall"}, {31'b0, bus.stall}, {31'b0, exp_stall});
        tick();
    endtask

    task automatic chk_ex(input string nm, input logic [3:0] c, input bit bub);
        chk({nm, "_ctrl"}, {28'b0, bus.redirection_ctrl}, {28'b0, c});
        chk({nm, "_ex_bubble"}, {31'b0, bus.ex_bubble}, {31'b0, bub});
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        tick();
        tick();
        started = 1;
        chk_ex("reset", 4'b0000, 1);
        chk("reset_stall", {31'b0, bus.stall}, 32'd0);
        rst = 0;

        // add $3<-$1,$2 ; sub $4<-$3,$5
        step("add3", 1, 1, 2, 1, 1, 1, 3, 0, 0, 0);
        chk_ex("add3", 4'b0000, 0);
        step("sub4", 1, 3, 5, 1, 1, 1, 4, 0, 0, 0);
        chk_ex("b2b_alu", 4'b0001, 0);

        // add $3 ; independent ; or $6<-$7,$3
        step("add3b", 1, 1, 2, 1, 1, 1, 3, 0, 0, 0);
        step("indep", 1, 12, 13, 1, 1, 1, 11, 0, 0, 0);
        step("or6", 1, 7, 3, 1, 1, 1, 6, 0, 0, 0);
        chk_ex("dist2_rt", 4'b1000, 0);

        // add $3 ; addi $3 ; and $8<-$3,$3
        step("add3c", 1, 1, 2, 1, 1, 1, 3, 0, 0, 0);
        step("addi3", 1, 1, 0, 1, 0, 1, 3, 0, 0, 0);
        step("and8", 1, 3, 3, 1, 1, 1, 8, 0, 0, 0);
        chk_ex("both_prod", 4'b0101, 0);

        // lw $9 ; add $10<-$9,$1 (stalls once, then forwards from MEM)
        step("lw9", 1, 1, 0, 1, 0, 1, 9, 1, 0, 0);
        step("ldu_stall", 1, 9, 1, 1, 1, 1, 10, 0, 0, 1);
        chk_ex("ldu_bubble", 4'b0000, 1);
        step("ldu_retry", 1, 9, 1, 1, 1, 1, 10, 0, 0, 0);
        chk_ex("ldu_fwd", 4'b0010, 0);
`ifdef REDIRECTION_STALL_COUNT_EN
        chk("ldu_stall_count", bus.stall_count, 32'd1);
`endif

        // writer of $0 then reader of $0
        step("wr0", 1, 1, 2, 1, 1, 1, 0, 0, 0, 0);
        step("rd0", 1, 0, 0, 1, 1, 1, 12, 0, 0, 0);
        chk_ex("reg0", 4'b0000, 0);

        // lw $9 ; dependent add killed by flush ; reader of $10
        step("lw9f", 1, 1, 0, 1, 0, 1, 9, 1, 0, 0);
        step("flush_add", 1, 9, 1, 1, 1, 1, 10, 0, 1, 0);
        chk_ex("flush", 4'b0000, 1);
        step("rd10", 1, 10, 10, 1, 1, 1, 13, 0, 0, 0);
        chk_ex("killed_no_fwd", 4'b0000, 0);

        // reset during a load-use stall
        step("lw9r", 1, 1, 0, 1, 0, 1, 9, 1, 0, 0);
        drive(1, 9, 1, 1, 1, 1, 10, 0, 0);
        #1;
        chk("midstall_stall", {31'b0, bus.stall}, 32'd1);
        rst = 1;
        tick();
        chk("post_rst_stall", {31'b0, bus.stall}, 32'd0);
        chk_ex("post_rst", 4'b0000, 1);
`ifdef REDIRECTION_STALL_COUNT_EN
        chk("post_rst_count", bus.stall_count, 32'd0);
`endif
        rst = 0;

        // randomized traffic, checked by the compare process every cycle
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 99) < 85,
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10);
            tick();
        end
        rst = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
